// File: rtl/abs_sum_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : abs_sum_pkg
// Purpose : Shared constants and FSM state type for the windowed abs-sum block.
// Rev     : 1.0  initial release
// ============================================================================
package abs_sum_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 8;
  localparam int WORD_W     = LANES * LANE_W;
  localparam int WORD_SUM_W = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FLUSH  = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  // |-128| = 128 still fits in LANE_W bits when read as unsigned
  function automatic logic [LANE_W-1:0] lane_abs(input logic [LANE_W-1:0] v);
    return v[LANE_W-1] ? (~v + LANE_W'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/abs_sum_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : abs_sum_window_ctrl_if
// Purpose : Config, sample-stream and result handshake bundle of the controller.
// Rev     : 1.0  initial release
// ============================================================================
interface abs_sum_window_ctrl_if #(
  parameter int WIN_LEN_W = 16,
  parameter int SUM_W     = 32
);
  import abs_sum_pkg::*;

  logic [WIN_LEN_W-1:0] cfg_win_len;
  logic [SUM_W-1:0]     cfg_thresh;
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SUM_W-1:0]     out_sum;
  logic                 out_detect;
  logic [WIN_LEN_W-1:0] out_win_idx;
  logic                 busy;

  modport slave (
    input  cfg_win_len, cfg_thresh, start, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_detect, out_win_idx, busy
  );

  modport master (
    output cfg_win_len, cfg_thresh, start, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_detect, out_win_idx, busy
  );

endinterface
`default_nettype wire

// File: rtl/abs_sum_window_ctrl_tree.sv
`default_nettype none
// ============================================================================
// Module  : abs_sum_tree
// Purpose : Combinational sum of the absolute values of 16 signed byte lanes.
// Rev     : 1.0  initial release
// ============================================================================
module abs_sum_tree
  import abs_sum_pkg::*;
(
  input  logic [WORD_W-1:0]     i_data,
  output logic [WORD_SUM_W-1:0] o_sum
);

  logic [LANE_W-1:0] w_abs [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_abs[g] = lane_abs(i_data[g*LANE_W +: LANE_W]);
  end

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_sum = o_sum + WORD_SUM_W'(w_abs[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/abs_sum_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : abs_sum_window_ctrl
// Purpose : Accumulates per-word lane abs sums over an N-word window and
//           reports sum + threshold detect. Define ABS_SUM_CONT_EN for
//           back-to-back windows without a start pulse.
// Rev     : 1.0  initial release
// ============================================================================
module abs_sum_window_ctrl
  import abs_sum_pkg::*;
#(
  parameter int WIN_LEN_W = 16,
  parameter int SUM_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  abs_sum_window_ctrl_if.slave  bus
);

`ifdef ABS_SUM_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  state_e                r_state;
  state_e                w_next;
  logic [WIN_LEN_W-1:0]  r_len;
  logic [WIN_LEN_W-1:0]  r_count;
  logic [WIN_LEN_W-1:0]  r_win_idx;
  logic [SUM_W-1:0]      r_thresh;
  logic [SUM_W-1:0]      r_acc;
  logic [WORD_SUM_W-1:0] r_psum;
  logic                  r_pvld;
  logic [WORD_SUM_W-1:0] w_word_sum;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_start_ok;
  logic                  w_out_hs;
  logic                  w_restart;
  logic                  w_load;

  abs_sum_tree u_tree (
    .i_data (bus.in_data),
    .o_sum  (w_word_sum)
  );

  assign w_in_ready = (r_state == S_ACCUM) && (r_count < r_len);
  assign w_accept   = w_in_ready && bus.in_valid;
  assign w_last     = w_accept && (r_count == r_len - WIN_LEN_W'(1));
  assign w_start_ok = (r_state == S_IDLE) && bus.start && !bus.abort &&
                      (bus.cfg_win_len != '0);
  assign w_out_hs   = (r_state == S_REPORT) && bus.out_ready;
  assign w_restart  = CONT_EN && w_out_hs && (bus.cfg_win_len != '0);
  assign w_load     = w_start_ok || w_restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start_ok) w_next = S_ACCUM;
        S_ACCUM:  if (w_last)     w_next = S_FLUSH;
        S_FLUSH:  w_next = S_REPORT;
        S_REPORT: if (w_out_hs)   w_next = w_restart ? S_ACCUM : S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Two-stage pipe: word sum lands in r_psum, folded into r_acc one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_thresh  <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_psum    <= '0;
      r_pvld    <= 1'b0;
      r_win_idx <= '0;
    end else if (bus.abort) begin
      r_count <= '0;
      r_acc   <= '0;
      r_pvld  <= 1'b0;
    end else begin
      if (w_load) begin
        r_len    <= bus.cfg_win_len;
        r_thresh <= bus.cfg_thresh;
        r_count  <= '0;
        r_acc    <= '0;
        r_pvld   <= 1'b0;
      end else begin
        r_pvld <= w_accept;
        if (w_accept) begin
          r_psum  <= w_word_sum;
          r_count <= r_count + WIN_LEN_W'(1);
        end
        if (r_pvld) begin
          r_acc <= r_acc + SUM_W'(r_psum);
        end
      end
      if (w_start_ok) begin
        r_win_idx <= '0;
      end else if (w_out_hs) begin
        r_win_idx <= r_win_idx + WIN_LEN_W'(1);
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_REPORT);
  assign bus.out_sum     = r_acc;
  assign bus.out_detect  = (r_state == S_REPORT) && (r_acc >= r_thresh);
  assign bus.out_win_idx = r_win_idx;
  assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_abs_sum_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_abs_sum_window_ctrl
// Purpose : Directed vector table plus hand sequences for abs_sum_window_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_abs_sum_window_ctrl;
  import abs_sum_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  abs_sum_window_ctrl_if bus ();

  abs_sum_window_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [15:0]  len;
    logic [31:0]  thresh;
    logic [127:0] data;
    bit           bubbles;
    logic [31:0]  exp_sum;
    logic         exp_det;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input vec_t v, input string tag);
    bus.cfg_win_len = v.len;
    bus.cfg_thresh  = v.thresh;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
    bus.cfg_win_len = '0;
    bus.cfg_thresh  = '1;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    for (int k = 0; k < int'(v.len); k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.data;
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      if (v.bubbles && k != int'(v.len) - 1) begin
        bus.in_data = '1;
        step();
      end
    end
    chk({tag, "_valid_early"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_flush_ready"}, 64'(bus.in_ready), 64'd0);
    step();
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(bus.out_sum), 64'(v.exp_sum));
    chk({tag, "_detect"}, 64'(bus.out_detect), 64'(v.exp_det));
    chk({tag, "_idx"}, 64'(bus.out_win_idx), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_after"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
    chk({tag, "_idx_after"}, 64'(bus.out_win_idx), 64'd1);
  endtask

  vec_t vecs [6];

  initial begin
    int acc_n;
    int res_n;
    int exp_res;
    int exp_acc;
    logic [31:0] r_sums [4];
    logic [15:0] r_idx  [4];
    vec_t v;

    // per word: 0x80 -> 2048, 0xFF -> 16, 0x7F -> 2032, 0x80/0x7F mix -> 2040, 0xFE/0x03 mix -> 40
    vecs[0] = '{16'd4, 32'd8192, {16{8'h80}}, 1'b0, 32'd8192, 1'b1};
    vecs[1] = '{16'd3, 32'd48,   {16{8'hFF}}, 1'b0, 32'd48,   1'b1};
    vecs[2] = '{16'd4, 32'd0,    {16{8'h7F}}, 1'b1, 32'd8128, 1'b1};
    vecs[3] = '{16'd2, 32'd4081, {8{8'h80, 8'h7F}}, 1'b0, 32'd4080, 1'b0};
    vecs[4] = '{16'd5, 32'd200,  {8{8'hFE, 8'h03}}, 1'b1, 32'd200, 1'b1};
    vecs[5] = '{16'd1, 32'd17,   {16{8'h01}}, 1'b0, 32'd16, 1'b0};

    bus.cfg_win_len = '0;
    bus.cfg_thresh  = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_out_detect", 64'(bus.out_detect), 64'd0);
    chk("rst_win_idx", 64'(bus.out_win_idx), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while the collector stalls
    bus.cfg_win_len = 16'd3;
    bus.cfg_thresh  = 32'd100;
    bus.start       = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {16{8'hFF}};
    step();
    step();
    step();
    chk("bp_flush_ready", 64'(bus.in_ready), 64'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum", 64'(bus.out_sum), 64'd48);
      chk("bp_detect", 64'(bus.out_detect), 64'd0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.in_valid    = 1'b0;
    bus.cfg_win_len = '0;
    bus.out_ready   = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_done_busy", 64'(bus.busy), 64'd0);

    // Abort after two words, then a clean window
    bus.cfg_win_len = 16'd4;
    bus.cfg_thresh  = 32'd0;
    bus.start       = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {16{8'h7F}};
    step();
    step();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("abort_no_result", 64'(bus.out_valid), 64'd0);
    end
    v = '{16'd4, 32'd8129, {16{8'h7F}}, 1'b0, 32'd8128, 1'b0};
    run_window(v, "post_abort");

    // Zero-length start and start+abort both stay idle
    bus.cfg_win_len = '0;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    chk("zero_len_busy", 64'(bus.busy), 64'd0);
    chk("zero_len_in_ready", 64'(bus.in_ready), 64'd0);
    bus.cfg_win_len = 16'd4;
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 64'(bus.busy), 64'd0);
    chk("start_abort_in_ready", 64'(bus.in_ready), 64'd0);

    // Six words offered against 2-word windows
    bus.cfg_win_len = 16'd2;
    bus.cfg_thresh  = 32'd0;
    bus.start       = 1'b1;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = {16{8'h01}};
    step();
    bus.start = 1'b0;
    acc_n = 0;
    res_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) begin
        if (res_n < 4) begin
          r_sums[res_n] = bus.out_sum;
          r_idx[res_n]  = bus.out_win_idx;
        end
        res_n++;
      end
      if (bus.in_valid && bus.in_ready) acc_n++;
      step();
      bus.in_valid = (acc_n < 6);
    end
`ifdef ABS_SUM_CONT_EN
    exp_res = 3;
    exp_acc = 6;
    chk("cont_busy_waiting", 64'(bus.busy), 64'd1);
`else
    exp_res = 1;
    exp_acc = 2;
    chk("single_idle", 64'(bus.busy), 64'd0);
`endif
    chk("multi_results", 64'(res_n), 64'(exp_res));
    chk("multi_accepts", 64'(acc_n), 64'(exp_acc));
    for (int i = 0; i < exp_res && i < res_n && i < 4; i++) begin
      chk($sformatf("multi_sum%0d", i), 64'(r_sums[i]), 64'd32);
      chk($sformatf("multi_idx%0d", i), 64'(r_idx[i]), 64'(i));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("multi_end_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-window
    bus.cfg_win_len = 16'd4;
    bus.cfg_thresh  = 32'd0;
    bus.start       = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {16{8'h01}};
    step();
    bus.in_valid = 1'b0;
    step();
    chk("pre_rst_sum", 64'(bus.out_sum), 64'd16);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("mid_rst_detect", 64'(bus.out_detect), 64'd0);
    chk("mid_rst_idx", 64'(bus.out_win_idx), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
